imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_pkg.sv | 16 +
 rtl/imem_loader.sv | 104 ++++++++++
 tb/tb_imem_loader.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types for the instruction-memory loader: FSM states and the
// bytes-per-instruction helper.
package imem_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } state_e;

  function automatic int bytes_per_instr(input int reg_bits);
    return reg_bits / 8;
  endfunction

endpackage : imem_loader_pkg

// File: rtl/imem_loader.sv
// Streams a program from a byte-wide host port into an external instruction
// memory and holds the stack machine until a whole number of instructions lands.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int REG_BITS   = 32,
  parameter int IMEM_BYTES = 256,
  localparam int BPI = bytes_per_instr(REG_BITS),
  localparam int AW  = $clog2(IMEM_BYTES),
  localparam int WCW = $clog2(IMEM_BYTES / BPI) + 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [7:0]     in_data,
  input  logic           in_last,
  output logic           imem_we,
  output logic [AW-1:0]  imem_addr,
  output logic [7:0]     imem_wdata,
  output logic           cpu_hold,
  output logic           done,
  output logic           err,
  output logic [WCW-1:0] word_count
);

  localparam int SH = $clog2(BPI);

  state_e           state_q, state_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic [WCW-1:0]   wc_q, wc_d;
  logic             we_q;
  logic [AW-1:0]    addr_q;
  logic [7:0]       wdata_q;
  logic             accept;
  logic [AW:0]      cnt_inc;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wc_d    = wc_q;
    accept  = in_valid && (state_q == ST_LOAD);
    cnt_inc = cnt_q + 1'b1;

    case (state_q)
      ST_LOAD: begin
        // start is deliberately ignored here; only a byte moves the FSM.
        if (accept) begin
          cnt_d = cnt_inc;
          if (in_last) begin
            if (cnt_inc[SH-1:0] == '0) begin
              state_d = ST_DONE;
              wc_d    = cnt_inc[AW:SH];
            end else begin
              state_d = ST_ERR;
            end
          end else if (cnt_q == (AW+1)'(IMEM_BYTES - 1)) begin
            state_d = ST_ERR;
          end
        end
      end
      default: begin
        if (start) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
          wc_d    = '0;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      wc_q    <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wc_q    <= wc_d;
      we_q    <= accept;
      if (accept) begin
        addr_q  <= cnt_q[AW-1:0];
        wdata_q <= in_data;
      end
    end
  end

  assign in_ready   = (state_q == ST_LOAD);
  assign cpu_hold   = (state_q != ST_DONE);
  assign done       = (state_q == ST_DONE);
  assign err        = (state_q == ST_ERR);
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign word_count = wc_q;

endmodule : imem_loader

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench: three loader configurations share one host
// stream; a byte-list model predicts the writes and the final status.
module tb_imem_loader;

  localparam int DEPTH [3] = '{256, 16, 256};
  localparam int BPI   [3] = '{4, 4, 2};
  localparam int BUDGET = 4000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] start_v;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;

  logic [2:0] rdy, we, hold, dn, er;
  logic [7:0] addr_a, addr_c, wd_a, wd_b, wd_c, wc_c;
  logic [3:0] addr_b;
  logic [6:0] wc_a;
  logic [2:0] wc_b;

  logic [7:0]  stream [$];
  logic [17:0] wq [$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imem_loader #(.REG_BITS(32), .IMEM_BYTES(256)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .in_valid(in_valid),
    .in_ready(rdy[0]), .in_data(in_data), .in_last(in_last), .imem_we(we[0]),
    .imem_addr(addr_a), .imem_wdata(wd_a), .cpu_hold(hold[0]), .done(dn[0]),
    .err(er[0]), .word_count(wc_a));

  imem_loader #(.REG_BITS(32), .IMEM_BYTES(16)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .in_valid(in_valid),
    .in_ready(rdy[1]), .in_data(in_data), .in_last(in_last), .imem_we(we[1]),
    .imem_addr(addr_b), .imem_wdata(wd_b), .cpu_hold(hold[1]), .done(dn[1]),
    .err(er[1]), .word_count(wc_b));

  imem_loader #(.REG_BITS(16), .IMEM_BYTES(256)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .in_valid(in_valid),
    .in_ready(rdy[2]), .in_data(in_data), .in_last(in_last), .imem_we(we[2]),
    .imem_addr(addr_c), .imem_wdata(wd_c), .cpu_hold(hold[2]), .done(dn[2]),
    .err(er[2]), .word_count(wc_c));

  always @(negedge clk) begin
    if (we[0]) wq.push_back({2'd0, addr_a, wd_a});
    if (we[1]) wq.push_back({2'd1, 4'd0, addr_b, wd_b});
    if (we[2]) wq.push_back({2'd2, addr_c, wd_c});
  end

  function automatic logic [7:0] addr_of(input int d);
    case (d)
      0:       return addr_a;
      1:       return {4'd0, addr_b};
      default: return addr_c;
    endcase
  endfunction

  function automatic logic [7:0] wd_of(input int d);
    case (d)
      0:       return wd_a;
      1:       return wd_b;
      default: return wd_c;
    endcase
  endfunction

  function automatic logic [7:0] wc_of(input int d);
    case (d)
      0:       return {1'b0, wc_a};
      1:       return {5'd0, wc_b};
      default: return wc_c;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle_outputs(input int d, input string tag);
    check({tag, "_hold"},  hold[d],   1);
    check({tag, "_done"},  dn[d],     0);
    check({tag, "_err"},   er[d],     0);
    check({tag, "_ready"}, rdy[d],    0);
    check({tag, "_we"},    we[d],     0);
    check({tag, "_wc"},    wc_of(d),  0);
  endtask

  // Offers the current stream to DUT d; optional mid-load start pulse and reset.
  task automatic run_load(input int d, input int gap_pct, input int mid_start, input int rst_after);
    int sent = 0;
    int cyc = 0;
    bit prev_acc = 1'b0;
    bit mid_fired = 1'b0;
    bit aborted = 1'b0;
    wq.delete();
    @(negedge clk);
    start_v[d] = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    start_v[d] = 1'b0;
    check($sformatf("ready_in_load[%0d]", d), rdy[d], 1);
    check($sformatf("hold_in_load[%0d]", d), hold[d], 1);
    forever begin
      check($sformatf("we_follows_accept[%0d]", d), we[d], prev_acc);
      if (rst_after >= 0 && sent == rst_after) begin
        #2 rst_n = 1'b0;
        #1 check_idle_outputs(d, "mid_reset");
        aborted = 1'b1;
        break;
      end
      if (sent == stream.size() || !rdy[d]) break;
      if (cyc >= BUDGET) begin
        check("cycle_budget", cyc, BUDGET - 1);
        break;
      end
      prev_acc  = ($urandom_range(99) >= gap_pct);
      in_valid  = prev_acc;
      in_data   = stream[sent];
      in_last   = (sent == stream.size() - 1);
      start_v[d] = (sent == mid_start) && !mid_fired;
      if (start_v[d]) mid_fired = 1'b1;
      if (prev_acc) sent++;
      cyc++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    start_v  = '0;
    if (aborted) begin
      repeat (3) begin
        @(negedge clk);
        check("we_in_reset", we[d], 0);
        check("hold_in_reset", hold[d], 1);
      end
      #2 rst_n = 1'b1;
    end else begin
      @(negedge clk);
      check($sformatf("we_after_stream[%0d]", d), we[d], 0);
    end
  endtask

  // Model: a load writes bytes in order until last, depth or reset cuts it off.
  task automatic check_result(input int d, input int rst_after);
    int n = stream.size();
    int exp_w, exp_wc;
    bit exp_done, exp_err;
    exp_wc = 0; exp_done = 1'b0; exp_err = 1'b0;
    if (rst_after >= 0) begin
      exp_w = rst_after;
    end else if (n > DEPTH[d]) begin
      exp_w = DEPTH[d];
      exp_err = 1'b1;
    end else begin
      exp_w = n;
      if (n % BPI[d] == 0) begin
        exp_done = 1'b1;
        exp_wc = n / BPI[d];
      end else begin
        exp_err = 1'b1;
      end
    end
    check($sformatf("write_count[%0d]", d), wq.size(), exp_w);
    for (int i = 0; i < wq.size() && i < exp_w; i++) begin
      logic [1:0] dd;
      logic [7:0] ia;
      dd = d[1:0];
      ia = i[7:0];
      check($sformatf("write[%0d][%0d]", d, i), wq[i], {dd, ia, stream[i]});
    end
    check($sformatf("done[%0d]", d), dn[d], exp_done);
    check($sformatf("err[%0d]", d), er[d], exp_err);
    check($sformatf("hold[%0d]", d), hold[d], !exp_done);
    check($sformatf("ready_after[%0d]", d), rdy[d], 0);
    check($sformatf("word_count[%0d]", d), wc_of(d), exp_wc);
  endtask

  task automatic random_stream(input int n);
    stream.delete();
    for (int i = 0; i < n; i++) stream.push_back(8'($urandom_range(255)));
  endtask

  initial begin
    logic [7:0] prog [16] = '{8'h2B, 8'hFF, 8'hFF, 8'hFC, 8'h3C, 8'h00, 8'h00, 8'h00,
                              8'h04, 8'h00, 8'h00, 8'h00, 8'h08, 8'h00, 8'h00, 8'h00};
    rst_n = 1'b0; start_v = '0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    #12;
    for (int d = 0; d < 3; d++) begin
      check_idle_outputs(d, $sformatf("reset[%0d]", d));
      check($sformatf("reset_addr[%0d]", d), addr_of(d), 0);
      check($sformatf("reset_wdata[%0d]", d), wd_of(d), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    stream.delete();
    foreach (prog[i]) stream.push_back(prog[i]);
    run_load(0, 0, -1, -1);  check_result(0, -1);
    run_load(0, 40, -1, -1); check_result(0, -1);

    random_stream(6);  run_load(0, 20, -1, -1); check_result(0, -1);
    random_stream(4);  run_load(0, 20, -1, -1); check_result(0, -1);

    random_stream(17); run_load(1, 25, -1, -1); check_result(1, -1);
    random_stream(16); run_load(1, 10, -1, -1); check_result(1, -1);

    random_stream(10); run_load(2, 30, 4, -1);  check_result(2, -1);
    random_stream(10); run_load(2, 30, -1, 5);  check_result(2, 5);

    for (int k = 0; k < 8; k++) begin
      int d = ($urandom_range(1) == 0) ? 0 : 2;
      random_stream($urandom_range(20, 1));
      run_load(d, $urandom_range(50), -1, -1);
      check_result(d, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule : tb_imem_loader
